uart_rx_monitor: RTL

//  Receive-side counterpart to the scripted register-bus stimulus that drives uart_core TX.

---
 rtl/uart_rx_monitor_if.sv | 24 ++
 rtl/uart_rx_monitor.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_monitor_if.sv
// Register-bus bundle between a stimulus/controller (master) and the UART receive monitor (slave).
interface uart_rx_monitor_if;
  logic        reg_we;
  logic        reg_re;
  logic [11:0] reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;

  modport master (
    output reg_we,
    output reg_re,
    output reg_addr,
    output reg_wdata,
    input  reg_rdata
  );

  modport slave (
    input  reg_we,
    input  reg_re,
    input  reg_addr,
    input  reg_wdata,
    output reg_rdata
  );
endinterface

// File: rtl/uart_rx_monitor.sv
// 8N1 UART receiver with an RX FIFO, sticky error flags and a small register-bus responder.
module uart_rx_monitor #(
  parameter int unsigned DEPTH   = 8,
  parameter logic [15:0] DIV_RST = 16'd43
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  uart_rx_monitor_if.slave bus,
  input  logic             rx_i,
  output logic             intr_rx,
  output logic             intr_rx_err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  localparam logic [11:0] ADDR_CTRL   = 12'h000;
  localparam logic [11:0] ADDR_RDATA  = 12'h004;
  localparam logic [11:0] ADDR_STATUS = 12'h008;
  localparam logic [11:0] ADDR_CLEAR  = 12'h00C;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            rx_meta_q, rx_sync_q, rx_prev_q;

  logic            ctrl_en_q, ctrl_en_d;
  logic [3:0]      ctrl_thr_q, ctrl_thr_d;
  logic [15:0]     ctrl_div_q, ctrl_div_d;

  logic [7:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;
  logic [31:0]     reg_rdata_q, reg_rdata_d;

  logic            rx_en_s, rx_fall_s;
  logic            push_req_s, fe_set_s, push_ok_s, ov_set_s;
  logic            wr_ctrl_s, wr_clear_s, rd_s, pop_s, flush_s, clr_err_s;
  logic            empty_s, full_s;
  logic [3:0]      thr_eff_s;
  logic [6:0]      level7_s;
  logic [31:0]     status_s;
  logic            unused_s;

  assign unused_s = ^bus.reg_wdata[30:20];

  assign rx_en_s   = ctrl_en_q && (ctrl_div_q >= 16'd2);
  assign rx_fall_s = rx_prev_q && !rx_sync_q;

  assign wr_ctrl_s  = bus.reg_we && (bus.reg_addr == ADDR_CTRL);
  assign wr_clear_s = bus.reg_we && (bus.reg_addr == ADDR_CLEAR);
  assign rd_s       = bus.reg_re && !bus.reg_we;
  assign empty_s    = (level_q == {LW{1'b0}});
  assign full_s     = (level_q == LVL_FULL);
  assign pop_s      = rd_s && (bus.reg_addr == ADDR_RDATA) && !empty_s;
  assign flush_s    = wr_clear_s && bus.reg_wdata[0];
  assign clr_err_s  = wr_clear_s && bus.reg_wdata[1];

  // A push into a full FIFO only succeeds when a pop frees the slot in the same cycle.
  assign push_ok_s  = push_req_s && !flush_s && (!full_s || pop_s);
  assign ov_set_s   = push_req_s && !flush_s && full_s && !pop_s;

  assign level7_s   = 7'(level_q);
  assign status_s   = {20'd0, overrun_q, frame_err_q, full_s, empty_s, 1'b0, level7_s};
  assign thr_eff_s  = (ctrl_thr_q == 4'd0) ? 4'd1 : ctrl_thr_q;

  assign intr_rx       = (level7_s >= {3'd0, thr_eff_s});
  assign intr_rx_err   = frame_err_q || overrun_q;
  assign bus.reg_rdata = reg_rdata_q;

  // Receive FSM: next state, baud counter, bit index and shift register.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    shreg_d    = shreg_q;
    push_req_s = 1'b0;
    fe_set_s   = 1'b0;
    if (!rx_en_s) begin
      state_d   = ST_IDLE;
      cnt_d     = 16'd0;
      bit_idx_d = 3'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rx_fall_s) begin
            state_d = ST_START;
            cnt_d   = 16'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_START: begin
          // Half-bit offset here puts every later sample in the middle of its bit.
          if (cnt_q == (ctrl_div_q >> 1)) begin
            cnt_d     = 16'd0;
            bit_idx_d = 3'd0;
            if (!rx_sync_q) begin
              state_d = ST_DATA;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        ST_DATA: begin
          if (cnt_q == (ctrl_div_q - 16'd1)) begin
            cnt_d     = 16'd0;
            shreg_d   = {rx_sync_q, shreg_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
              state_d = ST_STOP;
            end else begin
              state_d = ST_DATA;
            end
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        ST_STOP: begin
          if (cnt_q == (ctrl_div_q - 16'd1)) begin
            cnt_d   = 16'd0;
            state_d = ST_IDLE;
            if (rx_sync_q) begin
              push_req_s = 1'b1;
            end else begin
              fe_set_s = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = 16'd0;
        end
      endcase
    end
  end

  // FIFO pointers, level and sticky error flags; flush overrides push and pop.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    frame_err_d = fe_set_s || (frame_err_q && !clr_err_s);
    overrun_d   = ov_set_s || (overrun_q && !clr_err_s);
    if (flush_s) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      level_d  = {LW{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok_s, pop_s})
        2'b10:   level_d = level_q + LVL_ONE;
        2'b01:   level_d = level_q - LVL_ONE;
        default: level_d = level_q;
      endcase
    end
  end

  // Control register writes and registered read data.
  always_comb begin
    ctrl_en_d   = ctrl_en_q;
    ctrl_thr_d  = ctrl_thr_q;
    ctrl_div_d  = ctrl_div_q;
    reg_rdata_d = reg_rdata_q;
    if (wr_ctrl_s) begin
      ctrl_en_d  = bus.reg_wdata[31];
      ctrl_thr_d = bus.reg_wdata[19:16];
      ctrl_div_d = bus.reg_wdata[15:0];
    end else begin
      ctrl_en_d  = ctrl_en_q;
    end
    if (rd_s) begin
      case (bus.reg_addr)
        ADDR_CTRL:   reg_rdata_d = {ctrl_en_q, 11'd0, ctrl_thr_q, ctrl_div_q};
        ADDR_RDATA: begin
          if (pop_s) begin
            reg_rdata_d = {24'd0, mem_q[rd_ptr_q]};
          end else begin
            reg_rdata_d = 32'd0;
          end
        end
        ADDR_STATUS: reg_rdata_d = status_s;
        default:     reg_rdata_d = 32'd0;
      endcase
    end else begin
      reg_rdata_d = reg_rdata_q;
    end
  end

  // State registers; the synchroniser idles high so reset never looks like a start bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 16'd0;
      bit_idx_q   <= 3'd0;
      shreg_q     <= 8'd0;
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_prev_q   <= 1'b1;
      ctrl_en_q   <= 1'b0;
      ctrl_thr_q  <= 4'd1;
      ctrl_div_q  <= DIV_RST;
      wr_ptr_q    <= {AW{1'b0}};
      rd_ptr_q    <= {AW{1'b0}};
      level_q     <= {LW{1'b0}};
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      reg_rdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      rx_meta_q   <= rx_i;
      rx_sync_q   <= rx_meta_q;
      rx_prev_q   <= rx_sync_q;
      ctrl_en_q   <= ctrl_en_d;
      ctrl_thr_q  <= ctrl_thr_d;
      ctrl_div_q  <= ctrl_div_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      reg_rdata_q <= reg_rdata_d;
    end
  end

  // FIFO storage; contents are only meaningful below the level count, so no reset.
  always_ff @(posedge clk_i) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= shreg_q;
    end
  end

endmodule
